fetch_queue: RTL

Instruction-fetch queue between the program-counter register and the decode stage of the pipelined core. Each cycle it consumes the current PC, issues a fetch to the synchronous instruction memory, and buffers returning {pc, instr} pairs in a DEPTH-entry FIFO toward decode using a valid/ready handshake. When buffer plus in-flight capacity is exhausted it drives the PC stall input, so the PC holds. It drops all buffered and in-flight fetches on a redirect.

---
 rtl/fetch_queue.sv | 71 +++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch FIFO between the PC register and decode.
// Tracks one in-flight memory request and stalls the PC when the buffer plus in-flight capacity is full.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          FQ_clk_F_i,
  input  logic          FQ_rstn_F_i,
  input  logic [31:0]   FQ_pc_F_i,
  output logic          FQ_stall_F_o,
  input  logic          FQ_flush_F_i,
  output logic          FQ_imreq_F_o,
  output logic [31:0]   FQ_imaddr_F_o,
  input  logic          FQ_imvalid_F_i,
  input  logic [31:0]   FQ_imrdata_F_i,
  output logic          FQ_valid_D_o,
  input  logic          FQ_ready_D_i,
  output logic [31:0]   FQ_instr_D_o,
  output logic [31:0]   FQ_pc_D_o,
  output logic [CW-1:0] FQ_count_F_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   pc_mem_q  [DEPTH];
  logic [31:0]   ins_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ifv_q, ifv_d;
  logic [31:0]   ifpc_q, ifpc_d;
  logic [CW:0]   occ;
  logic          issue, push, pop;
  // Issue ignores a same-cycle pop so the check never relies on decode accepting.
  always_comb begin
    occ     = {1'b0, count_q} + {{CW{1'b0}}, ifv_q};
    issue   = FQ_rstn_F_i & ~FQ_flush_F_i & (occ < (CW+1)'(DEPTH));
    push    = FQ_imvalid_F_i & ifv_q & ~FQ_flush_F_i;
    pop     = FQ_valid_D_o & FQ_ready_D_i & ~FQ_flush_F_i;
    head_d  = FQ_flush_F_i ? '0 : head_q + AW'(pop);
    tail_d  = FQ_flush_F_i ? '0 : tail_q + AW'(push);
    count_d = FQ_flush_F_i ? '0 : count_q + CW'(push) - CW'(pop);
    ifv_d   = issue;
    ifpc_d  = issue ? FQ_pc_F_i : ifpc_q;
  end
  assign FQ_imreq_F_o  = issue;
  assign FQ_imaddr_F_o = FQ_pc_F_i;
  assign FQ_stall_F_o  = FQ_rstn_F_i & ~FQ_flush_F_i & ~issue;
  assign FQ_valid_D_o  = FQ_rstn_F_i & (count_q != '0);
  assign FQ_pc_D_o     = FQ_valid_D_o ? pc_mem_q[head_q] : '0;
  assign FQ_instr_D_o  = FQ_valid_D_o ? ins_mem_q[head_q] : '0;
  assign FQ_count_F_o  = count_q;
  always_ff @(posedge FQ_clk_F_i or negedge FQ_rstn_F_i) begin
    if (!FQ_rstn_F_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ifv_q   <= 1'b0;
      ifpc_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ifv_q   <= ifv_d;
      ifpc_q  <= ifpc_d;
    end
  end
  always_ff @(posedge FQ_clk_F_i) begin
    if (push) begin
      pc_mem_q[tail_q]  <= ifpc_q;
      ins_mem_q[tail_q] <= FQ_imrdata_F_i;
    end
  end
endmodule
